// File: rtl/ram_refresh_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_refresh_if
// Description : Signal bundle between the refresh request source, the CPU RAM
//               controller and the CAS-before-RAS refresh engine.
//               master : request source / CPU side (drives requests and bus
//                        status, observes strobes and hold).
//               slave  : refresh engine (ram_refresh).
//   RefReq   refresh request level          RefUrg   refresh urgent level
//   BACT     CPU bus cycle active           RAMCS    CPU cycle addresses RAM
//   RAMBusy  RAM controller mid-access      nRASref  refresh RAS, active low
//   nCASref  refresh CAS, active low        RefOwn   refresh owns the strobes
//   RAMHold  block new RAM accesses         RefDone  end-of-refresh pulse
//   Owe      owed-refresh count (debug)
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_refresh_if;
    logic       RefReq;
    logic       RefUrg;
    logic       BACT;
    logic       RAMCS;
    logic       RAMBusy;
    logic       nRASref;
    logic       nCASref;
    logic       RefOwn;
    logic       RAMHold;
    logic       RefDone;
    logic [1:0] Owe;

    modport master (
        output RefReq, RefUrg, BACT, RAMCS, RAMBusy,
        input  nRASref, nCASref, RefOwn, RAMHold, RefDone, Owe
    );

    modport slave (
        input  RefReq, RefUrg, BACT, RAMCS, RAMBusy,
        output nRASref, nCASref, RefOwn, RAMHold, RefDone, Owe
    );
endinterface
`default_nettype wire

// File: rtl/ram_refresh.sv
`default_nettype none
// ============================================================================
// Module      : ram_refresh
// Description : CAS-before-RAS DRAM refresh engine. Counts owed refreshes from
//               rising edges of RefReq, arbitrates against CPU RAM cycles,
//               holds off new CPU accesses when refresh becomes urgent and
//               sequences nCASref/nRASref through CSR, RAS and precharge.
// Ports       : CLK  - FSB clock, all logic on posedge
//               RES  - asynchronous active-high reset
//               bus  - ram_refresh_if.slave (requests, CPU status, strobes,
//                      hold, done pulse, owed count)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_refresh #(
    parameter int TCSR   = 1,   // cycles nCAS is low before nRAS falls
    parameter int TRAS   = 3,   // cycles nRAS is held low
    parameter int TRP    = 2,   // cycles of RAS precharge
    parameter int OWEMAX = 3    // saturation value of the owed counter
) (
    input  wire logic       CLK,
    input  wire logic       RES,
    ram_refresh_if.slave    bus
);

    localparam int c_tmax  = (TCSR > TRAS) ? ((TCSR > TRP) ? TCSR : TRP)
                                           : ((TRAS > TRP) ? TRAS : TRP);
    localparam int c_cnt_w = $clog2(c_tmax + 1);

    localparam logic [c_cnt_w-1:0] c_ld_csr = c_cnt_w'(TCSR);
    localparam logic [c_cnt_w-1:0] c_ld_ras = c_cnt_w'(TRAS);
    localparam logic [c_cnt_w-1:0] c_ld_pre = c_cnt_w'(TRP);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);
    localparam logic [1:0]         c_owe_max = 2'(OWEMAX);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_csr  = 2'd1;
    localparam logic [1:0] c_st_ras  = 2'd2;
    localparam logic [1:0] c_st_pre  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nx;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_req_prev;
    logic [1:0]         r_owe;
    logic               r_nras;
    logic               r_ncas;
    logic               r_own;
    logic               r_hold;
    logic               r_done;

    logic w_req_edge;
    logic w_cnt_last;
    logic w_start;
    logic w_done;

    always_comb begin
        w_req_edge = bus.RefReq & ~r_req_prev;
        w_cnt_last = (r_cnt == c_one);
        w_done     = (r_state == c_st_pre) && w_cnt_last;
        // A held bus lets refresh start even while the CPU is addressing RAM:
        // the CPU cycle is waiting on RAMHold and cannot begin its access.
        w_start    = (r_state == c_st_idle) && (r_owe != 2'd0) && !bus.RAMBusy &&
                     (!(bus.BACT && bus.RAMCS) || r_hold);

        w_state_nx = r_state;
        case (r_state)
            c_st_idle: if (w_start)    w_state_nx = c_st_csr;
            c_st_csr:  if (w_cnt_last) w_state_nx = c_st_ras;
            c_st_ras:  if (w_cnt_last) w_state_nx = c_st_pre;
            c_st_pre:  if (w_cnt_last) w_state_nx = c_st_idle;
            default:                   w_state_nx = c_st_idle;
        endcase
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_req_prev <= 1'b1;     // RefReq already high at release is not a new request
            r_owe      <= 2'd0;
            r_nras     <= 1'b1;
            r_ncas     <= 1'b1;
            r_own      <= 1'b0;
            r_hold     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_req_prev <= bus.RefReq;
            r_done     <= w_done;
            r_state    <= w_state_nx;

            // Request and completion in the same cycle cancel out, so a
            // request arriving at saturation is kept when a slot frees up.
            if (w_req_edge && !w_done) begin
                if (r_owe != c_owe_max)
                    r_owe <= r_owe + 2'd1;
            end else if (!w_req_edge && w_done && (r_owe != 2'd0)) begin
                r_owe <= r_owe - 2'd1;
            end

            // Looking at the next state keeps the hold asserted for every
            // cycle the engine is away from IDLE, including the first.
            r_hold <= ((r_owe != 2'd0) && (bus.RefUrg || (r_owe >= 2'd2))) ||
                      (w_state_nx != c_st_idle);

            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_cnt  <= c_ld_csr;
                        r_own  <= 1'b1;
                        r_ncas <= 1'b0;
                    end
                end
                c_st_csr: begin
                    if (w_cnt_last) begin
                        r_cnt  <= c_ld_ras;
                        r_nras <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                c_st_ras: begin
                    if (w_cnt_last) begin
                        r_cnt  <= c_ld_pre;
                        r_nras <= 1'b1;
                        r_ncas <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                c_st_pre: begin
                    if (w_cnt_last) begin
                        r_own <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                default: begin
                    r_nras <= 1'b1;
                    r_ncas <= 1'b1;
                    r_own  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.nRASref = r_nras;
    assign bus.nCASref = r_ncas;
    assign bus.RefOwn  = r_own;
    assign bus.RAMHold = r_hold;
    assign bus.RefDone = r_done;
    assign bus.Owe     = r_owe;

endmodule
`default_nettype wire
